// File: rtl/systolic_sched.sv
// Sequencer for an N x N systolic PE array: clears the PEs, streams skewed A/B operands, snapshots C, drains results.
// Optional cycle counter output perf_cycles is built when SYSTOLIC_SCHED_PERF_EN is defined.
module systolic_sched #(
    parameter int N          = 2,
    parameter int REG_WIDTH  = 8,
    parameter int OUT_WIDTH  = REG_WIDTH * 2,
    localparam int ADDR_W    = (N > 2) ? $clog2(N) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         mem_rd_en,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [N*REG_WIDTH-1:0]       a_mem_data,
    input  logic [N*REG_WIDTH-1:0]       b_mem_data,
    output logic                         pe_clear,
    output logic [N*REG_WIDTH-1:0]       a_edge,
    output logic [N*REG_WIDTH-1:0]       b_edge,
    input  logic [N*N*OUT_WIDTH-1:0]     c_flat,
    output logic [OUT_WIDTH-1:0]         res_data,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic                         res_last
`ifdef SYSTOLIC_SCHED_PERF_EN
    ,
    output logic [15:0]                  perf_cycles
`endif
);

    localparam int CNT_W = $clog2(N * N + 3 * N);
    localparam int IDX_W = $clog2(N * N);
    localparam logic [CNT_W-1:0] FEED_LAST = CNT_W'(3 * N - 3);
    localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(N * N - 1);
    localparam logic [CNT_W-1:0] N_C       = CNT_W'(N);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, SNAP, OUT} state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           done_q, done_d;
    logic [N*N-1:0][OUT_WIDTH-1:0]  buf_q, buf_d;
    logic [CNT_W-1:0]               cnt_nxt;
    logic                           accept_start;
    logic                           feed_load;
    logic                           clear_st;

    // A start coinciding with the done pulse is dropped.
    assign accept_start = (state_q == IDLE) && start && !done_q;
    assign cnt_nxt      = cnt_q + CNT_W'(1);
    assign feed_load    = (state_q == FEED) && (cnt_q < N_C);
    assign clear_st     = (state_q == CLEAR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        buf_d   = buf_q;
        unique case (state_q)
            IDLE:  if (accept_start) state_d = CLEAR;
            CLEAR: begin
                state_d = FEED;
                cnt_d   = '0;
            end
            FEED: begin
                if (cnt_q == FEED_LAST) begin
                    state_d = SNAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_nxt;
                end
            end
            SNAP: begin
                buf_d   = c_flat;
                state_d = OUT;
            end
            OUT: begin
                if (res_ready) begin
                    if (cnt_q == OUT_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_nxt;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        if (clear_st) begin
            mem_rd_en = 1'b1;
        end else if ((state_q == FEED) && (cnt_nxt < N_C)) begin
            mem_rd_en = 1'b1;
            mem_addr  = cnt_nxt[ADDR_W-1:0];
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign pe_clear  = clear_st;
    assign res_valid = (state_q == OUT);
    assign res_last  = res_valid && (cnt_q == OUT_LAST);
    assign res_data  = res_valid ? buf_q[cnt_q[IDX_W-1:0]] : '0;

    // Lane i is skewed by i register stages; lane 0 has no skew and forwards
    // the operand buffer's registered read data straight to the edge.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [REG_WIDTH-1:0] a_in, b_in;
        assign a_in = feed_load ? a_mem_data[i*REG_WIDTH +: REG_WIDTH] : '0;
        assign b_in = feed_load ? b_mem_data[i*REG_WIDTH +: REG_WIDTH] : '0;

        if (i == 0) begin : g_direct
            assign a_edge[REG_WIDTH-1:0] = a_in;
            assign b_edge[REG_WIDTH-1:0] = b_in;
        end else begin : g_dly
            logic [i-1:0][REG_WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;

            always_comb begin
                a_sh_d = '0;
                b_sh_d = '0;
                if (!clear_st) begin
                    a_sh_d[0] = a_in;
                    b_sh_d[0] = b_in;
                    for (int s = 1; s < i; s++) begin
                        a_sh_d[s] = a_sh_q[s-1];
                        b_sh_d[s] = b_sh_q[s-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_sh_q <= '0;
                    b_sh_q <= '0;
                end else begin
                    a_sh_q <= a_sh_d;
                    b_sh_q <= b_sh_d;
                end
            end

            assign a_edge[i*REG_WIDTH +: REG_WIDTH] = a_sh_q[i-1];
            assign b_edge[i*REG_WIDTH +: REG_WIDTH] = b_sh_q[i-1];
        end
    end

`ifdef SYSTOLIC_SCHED_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (accept_start)  perf_d = '0;
        else if (busy)     perf_d = perf_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif

endmodule
